// File: rtl/program_loader.sv
// Serial program loader: parses A5-framed byte streams and writes the payload into RAM.
// Build option: define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module program_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        load_done,
   output logic        load_error
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_LO,
      S_ADDR_HI,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [7:0] HEADER = 8'hA5;

   state_t      state;
   logic [15:0] addr;
   logic [15:0] count;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  sum;
`endif

   // Handshake: a byte is consumed on every rising edge where rx_valid=1; there is
   // no backpressure. Each consumed payload byte yields a one-cycle ram_we on the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         addr      <= 16'h0000;
         count     <= 16'h0000;
         ram_we    <= 1'b0;
         ram_addr  <= 16'h0000;
         ram_wdata <= 8'h00;
         cpu_hold  <= 1'b0;
         busy      <= 1'b0;
         load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum        <= 8'h00;
         load_error <= 1'b0;
`endif
      end else begin
         ram_we <= 1'b0;
         if (rx_valid) begin
            case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (rx_data == HEADER) begin
                     state     <= S_ADDR_LO;
                     cpu_hold  <= 1'b1;
                     busy      <= 1'b1;
                     load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                     sum        <= 8'h00;
                     load_error <= 1'b0;
`endif
                  end
               end
               S_ADDR_LO: begin
                  addr[7:0] <= rx_data;
                  state     <= S_ADDR_HI;
               end
               S_ADDR_HI: begin
                  addr[15:8] <= rx_data;
                  state      <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  count[7:0] <= rx_data;
                  state      <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  count[15:8] <= rx_data;
                  if ({rx_data, count[7:0]} == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= S_CSUM;
`else
                     state     <= S_DONE;
                     busy      <= 1'b0;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  ram_we    <= 1'b1;
                  ram_addr  <= addr;
                  ram_wdata <= rx_data;
                  addr      <= addr + 16'd1;
                  count     <= count - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                  sum <= sum + rx_data;
`endif
                  // Header bytes inside the payload are plain data; only the count ends a frame.
                  if (count == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= S_CSUM;
`else
                     state     <= S_DONE;
                     busy      <= 1'b0;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
`endif
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CSUM: begin
                  busy <= 1'b0;
                  if (rx_data == sum) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     // CPU stays held so a corrupt image never runs.
                     state      <= S_ERROR;
                     load_error <= 1'b1;
                  end
               end
`endif
               default: begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
               end
            endcase
         end
      end
   end

`ifndef LOADER_CHECKSUM_EN
   assign load_error = 1'b0;
`endif

endmodule
